// File: rtl/jogador_automatico.sv
// jogador_automatico: captures the game's LED show and replays it on botoes.
// Optional JOGADOR_ERRO_EN adds injetar_erro (rotates the last replayed play).
module jogador_automatico #(
    parameter int MAX_JOGADAS  = 16,
    parameter int PRESS_CYCLES = 10,
    parameter int GAP_CYCLES   = 10,
    parameter int SHOW_TIMEOUT = 1200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] leds,
    input  logic       pronto,
`ifdef JOGADOR_ERRO_EN
    input  logic       injetar_erro,
`endif
    output logic [3:0] botoes,
    output logic       jogando,
    output logic [4:0] n_jogadas,
    output logic       erro_captura,
    output logic [3:0] db_estado
);

    localparam int          AW      = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
    localparam logic [4:0]  MAX_N   = 5'(MAX_JOGADAS);
    localparam logic [15:0] PRESS_L = 16'(PRESS_CYCLES - 1);
    localparam logic [15:0] GAP_L   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] SHOW_L  = 16'(SHOW_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ESPERA_LED = 4'd1,
        CAPTURA    = 4'd2,
        ESPERA_FIM = 4'd3,
        PRESSIONA  = 4'd4,
        SOLTA      = 4'd5,
        PROXIMA    = 4'd6,
        FIM        = 4'd7
    } estado_t;

    estado_t     state_q;
    logic [3:0]  mem_q [MAX_JOGADAS];
    logic [4:0]  n_q;
    logic [4:0]  rd_q;
    logic [4:0]  rd_d;
    logic [15:0] cnt_q;
    logic [3:0]  botoes_q;
    logic [3:0]  botoes_d;
    logic        erro_q;
    logic [3:0]  mem_rd;
    logic        leds_nz;
    logic        leds_oh;
    logic        cheio;

    assign leds_nz = (leds != 4'd0);
    assign leds_oh = leds_nz && ((leds & (leds - 4'd1)) == 4'd0);
    assign cheio   = (n_q == MAX_N);

    // Read index of the play about to be (or being) pressed.
    always_comb begin
        rd_d = rd_q;
        if (state_q == ESPERA_FIM) begin
            rd_d = '0;
        end else if (state_q == PROXIMA) begin
            rd_d = rd_q + 5'd1;
        end
    end

    assign mem_rd = mem_q[rd_d[AW-1:0]];

`ifdef JOGADOR_ERRO_EN
    always_comb begin
        botoes_d = mem_rd;
        if (injetar_erro && (rd_d + 5'd1 == n_q)) begin
            botoes_d = {mem_rd[2:0], mem_rd[3]};
        end
    end
`else
    assign botoes_d = mem_rd;
`endif

    always_ff @(posedge clock) begin
        if (!reset || !habilitar) begin
            state_q  <= IDLE;
            n_q      <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            botoes_q <= '0;
            erro_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= ESPERA_LED;
                end
                ESPERA_LED, ESPERA_FIM: begin
                    if (leds_nz) begin
                        if (cheio) begin
                            erro_q  <= 1'b1;
                            state_q <= FIM;
                        end else begin
                            mem_q[n_q[AW-1:0]] <= leds;
                            n_q <= n_q + 5'd1;
                            if (leds_oh) begin
                                state_q <= CAPTURA;
                            end else begin
                                erro_q  <= 1'b1;
                                state_q <= FIM;
                            end
                        end
                    end else if (state_q == ESPERA_FIM) begin
                        if (cnt_q >= SHOW_L) begin
                            state_q  <= PRESSIONA;
                            rd_q     <= rd_d;
                            cnt_q    <= '0;
                            botoes_q <= botoes_d;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                CAPTURA: begin
                    // The first zero of the gap already counts toward the timeout.
                    if (!leds_nz) begin
                        state_q <= ESPERA_FIM;
                        cnt_q   <= 16'd1;
                    end
                end
                PRESSIONA: begin
                    if (cnt_q == PRESS_L) begin
                        state_q  <= SOLTA;
                        cnt_q    <= '0;
                        botoes_q <= '0;
                    end else begin
                        cnt_q    <= cnt_q + 16'd1;
                        botoes_q <= botoes_d;
                    end
                end
                SOLTA: begin
                    if (cnt_q == GAP_L) begin
                        state_q <= PROXIMA;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                PROXIMA: begin
                    if (rd_d < n_q) begin
                        state_q  <= PRESSIONA;
                        rd_q     <= rd_d;
                        cnt_q    <= '0;
                        botoes_q <= botoes_d;
                    end else begin
                        state_q <= ESPERA_LED;
                        n_q     <= '0;
                        rd_q    <= '0;
                    end
                end
                FIM: begin
                    botoes_q <= '0;
                end
                default: begin
                    state_q  <= IDLE;
                    botoes_q <= '0;
                end
            endcase
            if (pronto && state_q != IDLE) begin
                state_q  <= FIM;
                botoes_q <= '0;
            end
        end
    end

    assign botoes       = botoes_q;
    assign jogando      = (state_q != IDLE) && (state_q != FIM);
    assign n_jogadas    = n_q;
    assign erro_captura = erro_q;
    assign db_estado    = state_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: shows LED sequences, checks replay.
// Define JOGADOR_ERRO_EN to also exercise the error-injection port.
module tb_jogador_automatico;

    localparam int SHOW_T = 1200;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       habilitar = 1'b0;
    logic       pronto    = 1'b0;
    logic [3:0] leds      = 4'd0;
    logic [3:0] botoes;
    logic       jogando;
    logic [4:0] n_jogadas;
    logic       erro_captura;
    logic [3:0] db_estado;
`ifdef JOGADOR_ERRO_EN
    logic       injetar_erro = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q [$];

    always #5 clock = ~clock;

    jogador_automatico dut (
        .clock        (clock),
        .reset        (reset),
        .habilitar    (habilitar),
        .leds         (leds),
        .pronto       (pronto),
`ifdef JOGADOR_ERRO_EN
        .injetar_erro (injetar_erro),
`endif
        .botoes       (botoes),
        .jogando      (jogando),
        .n_jogadas    (n_jogadas),
        .erro_captura (erro_captura),
        .db_estado    (db_estado)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Press monitor: value from scoreboard, press length, press spacing.
    logic [3:0] b_prev     = 4'd0;
    int         cyc        = 0;
    int         hi_len     = 0;
    int         last_start = -1000;
    bit         abort      = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (botoes != 4'd0 && b_prev == 4'd0) begin
            if (exp_q.size() == 0) chk("press_extra", botoes, 0);
            else chk("press_val", botoes, exp_q.pop_front());
            if (cyc - last_start < 100)
                chk("press_period", cyc - last_start, 21);
            last_start = cyc;
            hi_len     = 1;
            abort      = 1'b0;
        end else if (botoes != 4'd0) begin
            hi_len++;
        end else if (b_prev != 4'd0 && !abort) begin
            chk("press_len", hi_len, 10);
        end
        if (!reset || !habilitar || pronto) abort = 1'b1;
        b_prev = botoes;
    end

    logic [3:0] seq3 [3] = '{4'b0001, 4'b0100, 4'b0010};

    initial begin
        tick(2);
        chk("rst_botoes", botoes, 0);
        chk("rst_estado", db_estado, 0);
        chk("rst_n", n_jogadas, 0);
        chk("rst_erro", erro_captura, 0);
        chk("rst_jogando", jogando, 0);
        reset = 1'b1;
        tick(3);
        chk("idle_hold", db_estado, 0);

        // Single play round
        habilitar = 1'b1;
        tick(1);
        chk("espera_led", db_estado, 1);
        chk("jogando", jogando, 1);
        exp_q.push_back(4'b0001);
        leds = 4'b0001;
        tick(1);
        chk("cap_n", n_jogadas, 1);
        chk("cap_estado", db_estado, 2);
        tick(499);
        leds = 4'd0;
        tick(SHOW_T - 1);
        chk("pre_press", botoes, 0);
        chk("espera_fim", db_estado, 3);
        tick(1);
        chk("first_press", botoes, 4'b0001);
        chk("pressiona", db_estado, 4);
        tick(10);
        chk("solta", db_estado, 5);
        chk("solta_bot", botoes, 0);
        tick(10);
        chk("proxima", db_estado, 6);
        tick(1);
        chk("volta_espera", db_estado, 1);
        chk("round_n_clear", n_jogadas, 0);

        // Three play round
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(seq3[i]);
            leds = seq3[i];
            tick(500);
            leds = 4'd0;
            if (i < 2) tick(500);
        end
        chk("n_three", n_jogadas, 3);
        tick(SHOW_T);
        chk("r3_first", botoes, 4'b0001);
        tick(62);
        chk("r3_last_proxima", db_estado, 6);
        tick(1);
        chk("r3_done", db_estado, 1);
        chk("r3_n_clear", n_jogadas, 0);
        chk("r3_sb_drain", exp_q.size(), 0);

        // Non one-hot LED
        leds = 4'b0101;
        tick(1);
        chk("oh_erro", erro_captura, 1);
        chk("oh_fim", db_estado, 7);
        chk("oh_jogando", jogando, 0);
        leds = 4'd0;
        tick(50);
        chk("fim_bot", botoes, 0);
        chk("fim_hold", db_estado, 7);
        habilitar = 1'b0;
        tick(1);
        chk("fim_idle", db_estado, 0);
        chk("idle_erro_clr", erro_captura, 0);

        // Overflow on the 17th play
        habilitar = 1'b1;
        tick(1);
        for (int i = 0; i < 17; i++) begin
            leds = 4'(1 << (i % 4));
            tick(3);
            if (i == 15) begin
                chk("ovf_n16", n_jogadas, 16);
                chk("ovf_no_erro", erro_captura, 0);
            end
            if (i == 16) begin
                chk("ovf_erro", erro_captura, 1);
                chk("ovf_fim", db_estado, 7);
                chk("ovf_n_hold", n_jogadas, 16);
            end
            leds = 4'd0;
            tick(3);
        end
        habilitar = 1'b0;
        tick(1);

        // pronto with a capture, and pronto against habilitar=0
        habilitar = 1'b1;
        tick(1);
        pronto = 1'b1;
        leds   = 4'b0010;
        tick(1);
        chk("pronto_cap_n", n_jogadas, 1);
        chk("pronto_cap_fim", db_estado, 7);
        pronto    = 1'b0;
        leds      = 4'd0;
        habilitar = 1'b0;
        tick(1);
        chk("fim_to_idle", db_estado, 0);
        habilitar = 1'b1;
        tick(1);
        pronto    = 1'b1;
        habilitar = 1'b0;
        tick(1);
        chk("hab_beats_pronto", db_estado, 0);
        pronto = 1'b0;

`ifdef JOGADOR_ERRO_EN
        habilitar    = 1'b1;
        injetar_erro = 1'b1;
        tick(1);
        exp_q.push_back(4'b0001);
        leds = 4'b0001;
        tick(500);
        leds = 4'd0;
        tick(500);
        exp_q.push_back(4'b1000);
        leds = 4'b0100;
        tick(500);
        leds = 4'd0;
        tick(SHOW_T);
        chk("inj_first", botoes, 4'b0001);
        tick(21);
        chk("inj_rot", botoes, 4'b1000);
        pronto = 1'b1;
        tick(1);
        chk("inj_pronto_fim", db_estado, 7);
        chk("inj_pronto_bot", botoes, 0);
        pronto       = 1'b0;
        habilitar    = 1'b0;
        injetar_erro = 1'b0;
        tick(1);
`endif

        // Reset in the middle of a press
        habilitar = 1'b1;
        tick(1);
        exp_q.push_back(4'b1000);
        leds = 4'b1000;
        tick(20);
        leds = 4'd0;
        tick(SHOW_T);
        chk("mid_press", botoes, 4'b1000);
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("mid_rst_bot", botoes, 0);
        chk("mid_rst_estado", db_estado, 0);
        chk("mid_rst_n", n_jogadas, 0);
        chk("mid_rst_erro", erro_captura, 0);
        reset = 1'b1;
        tick(2);
        chk("sb_final", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
